// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory on the CPU's data-side bus.
// It returns load data combinationally on the shared tristate databus.
// Stores go into a one-entry write buffer and retire to the array one edge
// later. Loads read from that buffer whenever it holds the addressed word.
// Optional feature macro: DMEM_STATS_EN adds saturating load/store counters.
// When DMEM_STATS_EN is undefined, both counter outputs are tied to 0.

module dmem_responder #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddrbus,
  inout  wire  [31:0] databus,
  input  logic        lw,
  input  logic        sw,
  output logic        err,
  output logic [15:0] load_count,
  output logic [15:0] store_count
);

  localparam int DEPTH = 1 << ADDR_W;

  // Bus protocol: lw/sw are per-cycle strobes with no handshake. An access
  // is accepted only when exactly one strobe is high, the address is word
  // aligned and reset is low. A load completes in its own cycle. A store is
  // taken at the edge that ends the cycle. No back-pressure exists.

  // ---------------------------------------------------------------------
  // Address decode and access classification
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] idx;
  logic              aligned;
  logic              load_ok;
  logic              store_ok;
  logic              access_bad;
  logic              unused_addr_bits;

  assign idx     = daddrbus[ADDR_W+1:2];
  assign aligned = (daddrbus[1:0] == 2'b00);

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_bits = ^daddrbus[31:ADDR_W+2];

  assign load_ok    = lw & ~sw & aligned & ~reset;
  assign store_ok   = sw & ~lw & aligned & ~reset;
  assign access_bad = (lw & sw) | ((lw | sw) & ~aligned);

  // ---------------------------------------------------------------------
  // Storage: array plus one-entry posted-store buffer
  // ---------------------------------------------------------------------
  logic [31:0]       mem_q [DEPTH];
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_idx_q,   buf_idx_d;
  logic [31:0]       buf_data_q,  buf_data_d;
  logic              err_q,       err_d;

  // Next-state logic for the write buffer and the sticky error flag.
  always_comb begin
    buf_valid_d = 1'b0;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;
    err_d       = err_q | access_bad;
    if (store_ok) begin
      buf_valid_d = 1'b1;
      buf_idx_d   = idx;
      buf_data_d  = databus;
    end
  end

  // Buffer and error registers. Reset drops a pending store without
  // writing it to the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_data_q  <= buf_data_d;
      err_q       <= err_d;
    end
  end

  // Retire the buffered entry on every non-reset edge. The buffer may take
  // a new store at the same edge, so back-to-back stores lose nothing.
  always_ff @(posedge clk) begin
    if (!reset && buf_valid_q) begin
      mem_q[buf_idx_q] <= buf_data_q;
    end
  end

  // ---------------------------------------------------------------------
  // Load path: buffer forwarding takes priority over the array
  // ---------------------------------------------------------------------
  logic        fwd_hit;
  logic [31:0] rdata;

  // Select load data. A store from the previous cycle is still in the buffer.
  always_comb begin
    fwd_hit = buf_valid_q && (buf_idx_q == idx);
    rdata   = fwd_hit ? buf_data_q : mem_q[idx];
  end

  assign databus = load_ok ? rdata : {32{1'bz}};
  assign err     = err_q;

  // ---------------------------------------------------------------------
  // Optional access statistics
  // ---------------------------------------------------------------------
`ifdef DMEM_STATS_EN
  logic [15:0] load_cnt_q,  load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;

  // Saturating increments. Illegal and misaligned accesses never count.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (load_ok && (load_cnt_q != 16'hFFFF)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (store_ok && (store_cnt_q != 16'hFFFF)) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`else
  assign load_count  = 16'd0;
  assign store_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// The reference model is an architectural memory. A store becomes visible
// in the cycle after it is issued. A reset in the cycle right after a store
// cancels that store. Undriven bus cycles read back as all ones because of
// a pull-up on databus.

module tb_dmem_responder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        lw       = 1'b0;
  logic        sw       = 1'b0;
  logic [31:0] daddrbus = '0;
  logic [31:0] tb_wdata = '0;
  logic        tb_drv   = 1'b0;
  logic        err;
  logic [15:0] load_count;
  logic [15:0] store_count;

  tri1 [31:0] databus;
  assign databus = tb_drv ? tb_wdata : {32{1'bz}};

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .daddrbus    (daddrbus),
    .databus     (databus),
    .lw          (lw),
    .sw          (sw),
    .err         (err),
    .load_count  (load_count),
    .store_count (store_count)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] mdl_mem   [DEPTH];
  logic        mdl_known [DEPTH];
  logic        mdl_err   = 1'b0;
  int          mdl_lc    = 0;
  int          mdl_sc    = 0;
  logic        started   = 1'b0;
  logic        undo_v    = 1'b0;
  int          undo_idx  = 0;
  logic [31:0] undo_val  = '0;
  logic        undo_known = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b0;
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic is_load(input logic l, input logic s, input logic [31:0] a);
    return l && !s && (a[1:0] == 2'b00);
  endfunction

  function automatic logic is_store(input logic l, input logic s, input logic [31:0] a);
    return s && !l && (a[1:0] == 2'b00);
  endfunction

  // Update the model at each edge.
  always @(posedge clk) begin
    if (reset) begin
      if (undo_v) begin
        mdl_mem[undo_idx]   <= undo_val;
        mdl_known[undo_idx] <= undo_known;
      end
      undo_v  <= 1'b0;
      mdl_err <= 1'b0;
      mdl_lc  <= 0;
      mdl_sc  <= 0;
      started <= 1'b1;
    end else begin
      undo_v <= 1'b0;
      if (is_store(lw, sw, daddrbus)) begin
        undo_v              <= 1'b1;
        undo_idx            <= widx(daddrbus);
        undo_val            <= mdl_mem[widx(daddrbus)];
        undo_known          <= mdl_known[widx(daddrbus)];
        mdl_mem[widx(daddrbus)]   <= databus;
        mdl_known[widx(daddrbus)] <= 1'b1;
        if (mdl_sc < 65535) mdl_sc <= mdl_sc + 1;
      end
      if (is_load(lw, sw, daddrbus) && mdl_lc < 65535) mdl_lc <= mdl_lc + 1;
      if ((lw && sw) || ((lw || sw) && daddrbus[1:0] != 2'b00)) mdl_err <= 1'b1;
    end
  end

  // Compare DUT outputs with the model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      chk("err", {31'd0, err}, {31'd0, mdl_err});
`ifdef DMEM_STATS_EN
      chk("load_count",  {16'd0, load_count},  32'(mdl_lc));
      chk("store_count", {16'd0, store_count}, 32'(mdl_sc));
`else
      chk("load_count",  {16'd0, load_count},  32'd0);
      chk("store_count", {16'd0, store_count}, 32'd0);
`endif
      if (reset || !is_load(lw, sw, daddrbus)) begin
        if (!sw || reset || lw || daddrbus[1:0] != 2'b00) begin
          if (!tb_drv) chk("bus_hiz", databus, 32'hFFFF_FFFF);
        end
      end else if (mdl_known[widx(daddrbus)]) begin
        chk("bus_load", databus, mdl_mem[widx(daddrbus)]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic l, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset    = r;
    lw       = l;
    sw       = s;
    daddrbus = a;
    tb_wdata = d;
    tb_drv   = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, 1'b0, a, 32'h0);
    @(negedge clk);
    chk(name, databus, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
    @(negedge clk);
    chk("lit_rst_bus", databus, 32'hFFFF_FFFF);
    idle();
    @(negedge clk);
    chk("lit_rst_err", {31'd0, err}, 32'd0);
    chk("lit_rst_lc", {16'd0, load_count}, 32'd0);
    chk("lit_rst_sc", {16'd0, store_count}, 32'd0);

    // Store, idle, load.
    store(32'h08, 32'hDEAD_BEEF);
    idle();
    load_chk("lit_ld08", 32'h08, 32'hDEAD_BEEF);
    chk("lit_err0", {31'd0, err}, 32'd0);

    // Forwarding from a store in the previous cycle, and a forwarding miss.
    store(32'h14, 32'h55AA_0005);
    idle();
    store(32'h10, 32'h1234_5678);
    load_chk("lit_fwd10", 32'h10, 32'h1234_5678);
    store(32'h10, 32'h8765_4321);
    load_chk("lit_nofwd14", 32'h14, 32'h55AA_0005);

    // Back-to-back stores.
    store(32'h00, 32'h0000_000A);
    store(32'h04, 32'h0000_000B);
    store(32'h00, 32'h0000_000C);
    idle();
    load_chk("lit_b2b00", 32'h00, 32'h0000_000C);
    load_chk("lit_b2b04", 32'h04, 32'h0000_000B);
    load_chk("lit_alias80", 32'h80, 32'h0000_000C);
    store(32'h7C, 32'h7777_7777);
    load_chk("lit_aliasFC", 32'hFC, 32'h7777_7777);

    // Misaligned accesses.
    load_chk("lit_mis_bus", 32'h82, 32'hFFFF_FFFF);
    idle();
    @(negedge clk);
    chk("lit_mis_err", {31'd0, err}, 32'd1);
    store(32'h05, 32'hBAD0_BAD0);
    load_chk("lit_mis_st", 32'h04, 32'h0000_000B);

    // Illegal lw+sw while a store is pending: the pending store still retires.
    store(32'h0C, 32'h0000_000D);
    drive(1'b0, 1'b1, 1'b1, 32'h04, 32'hEEEE_EEEE);
    idle();
    load_chk("lit_ill_retire", 32'h0C, 32'h0000_000D);
    load_chk("lit_ill_nost", 32'h04, 32'h0000_000B);
    chk("lit_err_sticky", {31'd0, err}, 32'd1);

    // Reset discards a pending store.
    store(32'h1C, 32'h1111_1111);
    idle();
    store(32'h1C, 32'h2222_2222);
    drive(1'b1, 1'b1, 1'b0, 32'h1C, 32'h0);
    @(negedge clk);
    chk("lit_rst_ld_hiz", databus, 32'hFFFF_FFFF);
    load_chk("lit_rst_discard", 32'h1C, 32'h1111_1111);
    chk("lit_rst_err_clr", {31'd0, err}, 32'd0);
    chk("lit_rst_cnt", {load_count, store_count}, 32'd0);

    // Statistics: three stores and two loads after a clean reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    store(32'h00, 32'h0000_0001);
    store(32'h04, 32'h0000_0002);
    store(32'h08, 32'h0000_0003);
    load_chk("lit_st_ld00", 32'h00, 32'h0000_0001);
    load_chk("lit_st_ld04", 32'h04, 32'h0000_0002);
    idle();
    @(negedge clk);
`ifdef DMEM_STATS_EN
    chk("lit_sc3", {16'd0, store_count}, 32'd3);
    chk("lit_lc2", {16'd0, load_count}, 32'd2);
`else
    chk("lit_sc0", {16'd0, store_count}, 32'd0);
    chk("lit_lc0", {16'd0, load_count}, 32'd0);
`endif
    idle();
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
